// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter and sequencer for the byte-serial memory controller.
// Latency: grant one cycle after eligibility; owner completion pulse one cycle after mem_done.
// Backpressure: one transaction in flight; rdy_in=0 freezes all state; UART stores held while io_buffer_full.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [1:0]  IO_HI        = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    output logic        if_is_c,
    input  logic        ls_req,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_type,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        mem_start,
    output logic        mem_is_if,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_type,
    input  logic        mem_done,
    input  logic [31:0] mem_rdata,
    input  logic        mem_is_c
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DRAIN = 2'd2} state_t;

    state_t     state;
    logic [3:0] streak;

    logic ls_io_hold;
    logic if_elig;
    logic ls_elig;
    logic pick_if;

    // The done pulses double as masks so a requester is never re-granted in its completion cycle.
    assign ls_io_hold = io_buffer_full && (ls_addr[17:16] == IO_HI) && ls_type[3];
    assign if_elig    = if_req && !if_done;
    assign ls_elig    = ls_req && !ls_done && !ls_io_hold;
    assign pick_if    = if_elig && (!ls_elig || (streak == LIMIT));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            streak    <= 4'd0;
            if_done   <= 1'b0;
            if_data   <= 32'd0;
            if_is_c   <= 1'b0;
            ls_done   <= 1'b0;
            ls_rdata  <= 32'd0;
            mem_start <= 1'b0;
            mem_is_if <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_type  <= 4'b0111;
        end else if (rdy_in) begin
            mem_start <= 1'b0;
            if_done   <= 1'b0;
            ls_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        streak <= 4'd0;
                    end else if (if_elig || ls_elig) begin
                        state     <= BUSY;
                        mem_start <= 1'b1;
                        if (pick_if) begin
                            mem_is_if <= 1'b1;
                            mem_addr  <= if_addr;
                            mem_wdata <= 32'd0;
                            mem_type  <= 4'b0010;
                            streak    <= 4'd0;
                        end else begin
                            mem_is_if <= 1'b0;
                            mem_addr  <= ls_addr;
                            mem_wdata <= ls_wdata;
                            mem_type  <= ls_type;
                            if (!if_elig)
                                streak <= 4'd0;
                            else if (streak < LIMIT)
                                streak <= streak + 4'd1;
                        end
                    end
                end
                BUSY: begin
                    if (mem_done) begin
                        state <= IDLE;
                        if (clear) begin
                            streak <= 4'd0;
                        end else if (mem_is_if) begin
                            if_done <= 1'b1;
                            if_data <= mem_rdata;
                            if_is_c <= mem_is_c;
                        end else begin
                            ls_done  <= 1'b1;
                            ls_rdata <= mem_rdata;
                        end
                    end else if (clear) begin
                        // Downstream transaction is left to finish; its result is discarded in DRAIN.
                        state  <= DRAIN;
                        streak <= 4'd0;
                    end
                end
                DRAIN: begin
                    if (mem_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, contention/starvation, IO hold, clear, reset and stall.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear, io_buffer_full;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        if_is_c;
    logic        ls_req;
    logic [31:0] ls_addr, ls_wdata;
    logic [3:0]  ls_type;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        mem_start, mem_is_if;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_type;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        mem_is_c;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] S_IDLE = 32'd0, S_BUSY = 32'd1, S_DRAIN = 32'd2;

    mem_arbiter #(.STARVE_LIMIT(4), .IO_HI(2'b11)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data), .if_is_c(if_is_c),
        .ls_req(ls_req), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_type(ls_type),
        .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_start(mem_start), .mem_is_if(mem_is_if), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_type(mem_type), .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_is_c(mem_is_c)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Grant order and streak after each grant with both requesters contending (1 = fetch).
    logic       exp_f [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic [3:0] exp_s [10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'd0;
        ls_req = 1'b0; ls_addr = 32'd0; ls_wdata = 32'd0; ls_type = 4'd0;
        mem_done = 1'b0; mem_rdata = 32'd0; mem_is_c = 1'b0;

        // Reset values
        tick(); tick();
        chk("rst_state", 32'(dut.state), S_IDLE);
        chk("rst_mem_start", 32'(mem_start), 32'd0);
        chk("rst_mem_type", 32'(mem_type), 32'h7);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_dones", {30'd0, if_done, ls_done}, 32'd0);
        rst_in = 1'b0;
        tick();

        // Fetch only
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        chk("f_start", 32'(mem_start), 32'd1);
        chk("f_is_if", 32'(mem_is_if), 32'd1);
        chk("f_type", 32'(mem_type), 32'h2);
        chk("f_addr", mem_addr, 32'h100);
        tick();
        chk("f_start_pulse", 32'(mem_start), 32'd0);
        tick();
        mem_done = 1'b1; mem_rdata = 32'h00A00093; mem_is_c = 1'b0;
        tick();
        mem_done = 1'b0; if_req = 1'b0;
        chk("f_done", 32'(if_done), 32'd1);
        chk("f_data", if_data, 32'h00A00093);
        chk("f_is_c", 32'(if_is_c), 32'd0);
        chk("f_idle", 32'(dut.state), S_IDLE);
        tick();
        chk("f_done_end", 32'(if_done), 32'd0);
        chk("f_no_regrant", 32'(mem_start), 32'd0);

        // Contention and starvation; requests re-presented two cycles after each completion
        if_addr = 32'h400; ls_addr = 32'h2000; ls_type = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            if_req = 1'b1; ls_req = 1'b1;
            tick();
            chk($sformatf("c_start_%0d", i), 32'(mem_start), 32'd1);
            chk($sformatf("c_owner_%0d", i), 32'(mem_is_if), 32'(exp_f[i]));
            chk($sformatf("c_streak_%0d", i), 32'(dut.streak), 32'(exp_s[i]));
            tick();
            mem_done = 1'b1; mem_rdata = 32'h1000 + 32'(i);
            if_req = 1'b0; ls_req = 1'b0;
            tick();
            mem_done = 1'b0;
            chk($sformatf("c_done_%0d", i), {30'd0, if_done, ls_done},
                exp_f[i] ? 32'd2 : 32'd1);
            tick();
        end

        // IO hold: UART store blocked while buffer full, fetch proceeds
        io_buffer_full = 1'b1;
        ls_req = 1'b1; ls_addr = 32'h30000; ls_type = 4'b1000; ls_wdata = 32'hDEADBEEF;
        if_req = 1'b1; if_addr = 32'h200;
        tick();
        chk("io_f_start", 32'(mem_start), 32'd1);
        chk("io_f_is_if", 32'(mem_is_if), 32'd1);
        tick();
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0; if_req = 1'b0;
        chk("io_f_done", 32'(if_done), 32'd1);
        tick();
        chk("io_held_1", 32'(mem_start), 32'd0);
        tick();
        chk("io_held_2", 32'(mem_start), 32'd0);
        chk("io_held_idle", 32'(dut.state), S_IDLE);
        io_buffer_full = 1'b0;
        tick();
        chk("io_s_start", 32'(mem_start), 32'd1);
        chk("io_s_is_if", 32'(mem_is_if), 32'd0);
        chk("io_s_type3", 32'(mem_type[3]), 32'd1);
        chk("io_s_addr", mem_addr, 32'h30000);
        chk("io_s_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0; ls_req = 1'b0;
        chk("io_s_done", 32'(ls_done), 32'd1);
        tick();

        // Clear mid-load, then fetch presented during DRAIN is granted only after drain
        ls_req = 1'b1; ls_addr = 32'h1000; ls_type = 4'b0100;
        tick();
        chk("cl_start", 32'(mem_start), 32'd1);
        clear = 1'b1; ls_req = 1'b0;
        tick();
        clear = 1'b0;
        chk("cl_drain", 32'(dut.state), S_DRAIN);
        if_req = 1'b1; if_addr = 32'h300;
        tick();
        chk("cl_drain_ignore", 32'(mem_start), 32'd0);
        mem_done = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_done = 1'b0;
        chk("cl_idle", 32'(dut.state), S_IDLE);
        chk("cl_no_done", {30'd0, if_done, ls_done}, 32'd0);
        tick();
        chk("cl_f_start", 32'(mem_start), 32'd1);
        chk("cl_f_addr", mem_addr, 32'h300);

        // Clear coincident with mem_done on a fetch
        tick();
        mem_done = 1'b1; clear = 1'b1;
        tick();
        mem_done = 1'b0; clear = 1'b0; if_req = 1'b0;
        chk("cd_no_if_done", 32'(if_done), 32'd0);
        chk("cd_idle", 32'(dut.state), S_IDLE);
        tick();
        chk("cd_quiet", 32'(mem_start), 32'd0);

        // Reset mid-transaction
        ls_req = 1'b1; ls_addr = 32'h1234; ls_type = 4'b1001; ls_wdata = 32'h55;
        tick();
        chk("r_start", 32'(mem_start), 32'd1);
        rst_in = 1'b1; ls_req = 1'b0;
        tick();
        rst_in = 1'b0;
        chk("r_state", 32'(dut.state), S_IDLE);
        chk("r_mem_start", 32'(mem_start), 32'd0);
        chk("r_mem_addr", mem_addr, 32'd0);
        chk("r_mem_wdata", mem_wdata, 32'd0);
        chk("r_mem_type", 32'(mem_type), 32'h7);
        chk("r_mem_is_if", 32'(mem_is_if), 32'd0);

        // Stall stretches the ls_done pulse
        ls_req = 1'b1; ls_addr = 32'h40; ls_type = 4'b0000;
        tick();
        chk("st_start", 32'(mem_start), 32'd1);
        tick();
        mem_done = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_done = 1'b0; ls_req = 1'b0;
        chk("st_done", 32'(ls_done), 32'd1);
        chk("st_rdata", ls_rdata, 32'hCAFEF00D);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("st_hold_%0d", i), 32'(ls_done), 32'd1);
        end
        rdy_in = 1'b1;
        tick();
        chk("st_release", 32'(ls_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer in front of the single-port byte-serial memory controller. Accepts instruction-fetch requests from the fetch unit and load/store requests from the load-store buffer. Issues exactly one transaction at a time downstream, routes the completion back to the owner, enforces a fetch anti-starvation limit, holds UART-region stores while the UART buffer is full, and drains in-flight work on a pipeline clear.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive LSB grants made while a fetch is pending before the fetch is forced to win; range 1..15.
- IO_HI, 2'b11: value of addr[17:16] that marks the UART/IO region.

Ports:
- clk_in  in  1  system clock; all logic on rising edge.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  global enable; when low every register holds its value.
- clear  in  1  pipeline flush; sampled only when rdy_in=1.
- io_buffer_full  in  1  UART buffer full.
- if_req  in  1  fetch request, level; held until if_done.
- if_addr  in  32  fetch address.
- if_done  out  1  one-cycle fetch completion pulse.
- if_data  out  32  fetched instruction; valid while if_done=1.
- if_is_c  out  1  fetched instruction is compressed; valid while if_done=1.
- ls_req  in  1  load/store request, level; held until ls_done.
- ls_addr  in  32  load/store address.
- ls_wdata  in  32  store data.
- ls_type  in  4  access type, passed through; bit 3 = store.
- ls_done  out  1  one-cycle load/store completion pulse.
- ls_rdata  out  32  load result; valid while ls_done=1.
- mem_start  out  1  one-cycle transaction start pulse to the controller.
- mem_is_if  out  1  1 = fetch transaction, 0 = load/store.
- mem_addr  out  32  transaction address.
- mem_wdata  out  32  store data.
- mem_type  out  4  ls_type for load/store; 4'b0010 for fetch.
- mem_done  in  1  one-cycle completion from the controller.
- mem_rdata  in  32  read data; valid with mem_done.
- mem_is_c  in  1  compressed flag; valid with mem_done.

## Operation
- States: IDLE, BUSY, DRAIN.
- IDLE eligibility:
  - Fetch is eligible when if_req=1 and if_done=0.
  - LSB is eligible when ls_req=1, ls_done=0, and not (io_buffer_full=1 and ls_addr[17:16]==IO_HI and ls_type[3]=1).
  - The done mask prevents re-granting a requester during its completion cycle.
- IDLE selection:
  - The LSB wins by default.
  - The fetch wins when it is the only eligible requester, or when streak==STARVE_LIMIT.
- Grant:
  - Register mem_addr/mem_wdata/mem_type/mem_is_if from the winner.
  - Set mem_start=1 for the next cycle and go to BUSY.
  - Mem_* fields stay stable until the transaction ends.
- streak (4-bit):
  - Increments on an LSB grant while the fetch is eligible.
  - Clears on a fetch grant.
  - Clears on an LSB grant with the fetch not eligible.
  - Saturates at STARVE_LIMIT.
- BUSY + mem_done:
  - Return to IDLE.
  - Next cycle, pulse if_done (if_data=mem_rdata, if_is_c=mem_is_c) or ls_done (ls_rdata=mem_rdata) according to mem_is_if.
- clear while IDLE: no grant that cycle; streak cleared.
- clear while BUSY without mem_done:
  - Go to DRAIN; streak cleared.
  - The downstream transaction is never aborted, so a store in progress completes in memory.
- clear in the same cycle as mem_done: go to IDLE with no done pulse.
- DRAIN: wait for mem_done, then go to IDLE with no done pulse. Requests are ignored while in DRAIN.
- rst_in has priority over clear and rdy_in and is honoured mid-transaction.
  - State goes to IDLE and streak to 0.
  - All outputs go to 0, except mem_type, which resets to 4'b0111.

## Timing
- Grant latency: a request eligible in IDLE cycle t gives mem_start=1 in cycle t+1.
- mem_start is high for exactly one cycle per transaction.
- Completion: mem_done in cycle d gives the owner's done pulse in cycle d+1, with the arbiter already in IDLE in cycle d+1.
- Back-to-back: the other requester can be granted in cycle d+1 (mem_start in d+2). The same requester is masked in d+1 and can be granted in d+2 at the earliest.
- mem_done outside BUSY/DRAIN is ignored.
- mem_start and mem_done never coincide.
- rdy_in=0: no state change; pulse outputs keep their value, so a pulse spans the stalled cycles and ends one enabled cycle after.

## Test plan
- Fetch only:
  - Stimulus: if_req=1, if_addr=0x100; mem_done in 3rd BUSY cycle with mem_rdata=0x00A00093, mem_is_c=0.
  - Response: mem_start one cycle after the request, mem_is_if=1, mem_type=4'b0010; if_done pulse one cycle after mem_done with if_data=0x00A00093.
- Contention and starvation (STARVE_LIMIT=4):
  - Stimulus: if_req and ls_req held high; each transaction completes.
  - Response: grant order L,L,L,L,F,L,L,L,L,F; streak returns to 0 after each F.
- IO hold:
  - Stimulus: io_buffer_full=1, store to 0x30000, fetch pending.
  - Response: fetch granted, store not granted.
  - Stimulus: io_buffer_full=0.
  - Response: store granted next IDLE cycle with mem_type bit3=1.
- Clear mid-load:
  - Stimulus: clear in BUSY on a load to 0x1000; mem_done two cycles later.
  - Response: DRAIN; no ls_done; IDLE after mem_done; new fetch granted afterwards.
- Clear coincident with mem_done on a fetch: no if_done; IDLE next cycle.
- Reset and stall:
  - Stimulus: rst_in in BUSY.
  - Response: IDLE and all outputs at reset values the next cycle.
  - Stimulus: rdy_in=0 for 3 cycles during an ls_done pulse.
  - Response: ls_done held for those 3 cycles and the first enabled cycle, then low.
